// File: rtl/segre_mmu_dcache_fill.sv
// Data-cache miss responder: optional dirty-victim writeback, lane fetch from memory,
// one-cycle fill-ready pulse back to the tag stage, plus miss/writeback counters.
module segre_mmu_dcache_fill #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LANE_W = 128,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              dc_miss_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_victim_dirty_i,
    input  logic [ADDR_W-1:0] dc_victim_addr_i,
    input  logic [LANE_W-1:0] dc_victim_data_i,
    output logic              mmu_data_rdy_o,
    output logic [LANE_W-1:0] mmu_data_o,
    output logic [ADDR_W-1:0] mmu_addr_o,
    output logic              mmu_busy_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LANE_W-1:0] mem_wr_data_o,
    input  logic              mem_ack_i,
    input  logic [LANE_W-1:0] mem_rd_data_i,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o
);

    localparam int unsigned OFF = $clog2(LANE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, victim_addr_q, mmu_addr_q;
    logic [LANE_W-1:0] victim_data_q, mmu_data_q;
    logic [CNT_W-1:0]  miss_cnt_q, wb_cnt_q;
    logic              accept, wb_done, fill_done;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Memory-side outputs are decoded from state and captured registers only,
    // so nothing on the input side reaches an output combinationally.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        wb_done       = 1'b0;
        fill_done     = 1'b0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        unique case (state_q)
            IDLE: begin
                if (dc_miss_i) begin
                    accept  = 1'b1;
                    state_d = dc_victim_dirty_i ? WB : FILL;
                end
            end
            WB: begin
                mem_wr_o      = 1'b1;
                mem_addr_o    = victim_addr_q;
                mem_wr_data_o = victim_data_q;
                if (mem_ack_i) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = fill_addr_q;
                if (mem_ack_i) begin
                    fill_done = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            fill_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            mmu_addr_q    <= '0;
            mmu_data_q    <= '0;
            miss_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            if (accept) begin
                fill_addr_q   <= dc_addr_i & ALIGN_MASK;
                victim_addr_q <= dc_victim_addr_i & ALIGN_MASK;
                victim_data_q <= dc_victim_data_i;
                miss_cnt_q    <= miss_cnt_q + CNT_W'(1);
            end
            if (wb_done) wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            if (fill_done) begin
                mmu_data_q <= mem_rd_data_i;
                mmu_addr_q <= fill_addr_q;
            end
        end
    end

    assign mmu_data_rdy_o = (state_q == RESP);
    assign mmu_busy_o     = (state_q != IDLE);
    assign mmu_data_o     = mmu_data_q;
    assign mmu_addr_o     = mmu_addr_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign wb_cnt_o       = wb_cnt_q;

endmodule

// File: tb/tb_segre_mmu_dcache_fill.sv
// Scoreboard bench for segre_mmu_dcache_fill: driver plays the tag stage and memory,
// a negedge monitor checks every ready pulse against queued expectations.
module tb_segre_mmu_dcache_fill;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int CW = 4;
    localparam logic [AW-1:0] MASK = 32'hFFFF_FFF0;

    logic          clk = 1'b0;
    logic          rsn = 1'b0;
    logic          dc_miss = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic          dc_dirty = 1'b0;
    logic [AW-1:0] dc_vaddr = '0;
    logic [LW-1:0] dc_vdata = '0;
    logic          rdy, busy, mem_rd, mem_wr, mem_ack = 1'b0;
    logic [LW-1:0] mmu_data, mem_wdata, mem_rdata = '0;
    logic [AW-1:0] mmu_addr, mem_addr;
    logic [CW-1:0] miss_cnt, wb_cnt;

    segre_mmu_dcache_fill #(.ADDR_W(AW), .LANE_W(LW), .CNT_W(CW)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .dc_miss_i(dc_miss), .dc_addr_i(dc_addr), .dc_victim_dirty_i(dc_dirty),
        .dc_victim_addr_i(dc_vaddr), .dc_victim_data_i(dc_vdata),
        .mmu_data_rdy_o(rdy), .mmu_data_o(mmu_data), .mmu_addr_o(mmu_addr),
        .mmu_busy_o(busy), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rd_data_i(mem_rdata),
        .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [CW-1:0] mc;
        logic [CW-1:0] wc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] m_miss = '0;
    logic [CW-1:0] m_wb = '0;
    logic [AW-1:0] last_addr = '0;
    logic [LW-1:0] last_data = '0;
    logic          prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero();
        chk("rst_rdy", LW'(rdy), '0);
        chk("rst_data", mmu_data, '0);
        chk("rst_maddr", LW'(mmu_addr), '0);
        chk("rst_busy", LW'(busy), '0);
        chk("rst_rd", LW'(mem_rd), '0);
        chk("rst_wr", LW'(mem_wr), '0);
        chk("rst_addr", LW'(mem_addr), '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_mcnt", LW'(miss_cnt), '0);
        chk("rst_wcnt", LW'(wb_cnt), '0);
    endtask

    // Issues one miss starting in IDLE and services memory; returns at the RESP-cycle negedge.
    task automatic do_miss(input logic [AW-1:0] addr, input bit dirty, input logic [AW-1:0] vaddr,
                           input logic [LW-1:0] vdata, input int wb_wait, input int rd_wait,
                           input logic [LW-1:0] rdata, input bit ign);
        exp_t e;
        @(negedge clk);
        chk("idle_busy", LW'(busy), '0);
        chk("idle_miss_cnt", LW'(miss_cnt), LW'(m_miss));
        chk("hold_addr", LW'(mmu_addr), LW'(last_addr));
        chk("hold_data", mmu_data, last_data);
        dc_miss = 1'b1; dc_addr = addr; dc_dirty = dirty; dc_vaddr = vaddr; dc_vdata = vdata;
        m_miss = m_miss + 1'b1;
        if (dirty) m_wb = m_wb + 1'b1;
        e.addr = addr & MASK; e.data = rdata; e.mc = m_miss; e.wc = m_wb;
        sb.push_back(e);
        last_addr = addr & MASK;
        last_data = rdata;
        @(negedge clk);
        dc_miss = ign;
        if (ign) begin dc_addr = ~addr; dc_vaddr = ~vaddr; end
        if (dirty) begin
            for (int i = 0; i <= wb_wait; i++) begin
                chk("wb_wr", LW'(mem_wr), LW'(1));
                chk("wb_rd", LW'(mem_rd), '0);
                chk("wb_addr", LW'(mem_addr), LW'(vaddr & MASK));
                chk("wb_wdata", mem_wdata, vdata);
                mem_ack = (i == wb_wait);
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        for (int i = 0; i <= rd_wait; i++) begin
            chk("fill_rd", LW'(mem_rd), LW'(1));
            chk("fill_wr", LW'(mem_wr), '0);
            chk("fill_addr", LW'(mem_addr), LW'(addr & MASK));
            chk("fill_busy", LW'(busy), LW'(1));
            mem_ack   = (i == rd_wait);
            mem_rdata = (i == rd_wait) ? rdata : ~rdata;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsn && busy) begin
            checks++;
            if (mem_rd && mem_wr) begin
                errors++;
                $display("FAIL rd_wr_overlap actual=%0b%0b required=not both", mem_rd, mem_wr);
            end
        end
        if (rsn && rdy) begin
            checks++;
            if (prev_rdy) begin
                errors++;
                $display("FAIL rdy_pulse_len actual=2+ cycles required=1 cycle");
            end
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rdy actual=pulse addr=%0h required=no pulse", mmu_addr);
            end else begin
                e = sb.pop_front();
                chk("rdy_addr", LW'(mmu_addr), LW'(e.addr));
                chk("rdy_data", mmu_data, e.data);
                chk("rdy_miss_cnt", LW'(miss_cnt), LW'(e.mc));
                chk("rdy_wb_cnt", LW'(wb_cnt), LW'(e.wc));
            end
        end
        prev_rdy = rsn && rdy;
    end

    initial begin
        #12;
        check_zero();
        @(negedge clk); rsn = 1'b1;

        // clean miss, ack on the first FILL cycle
        do_miss(32'h0000_1234, 1'b0, '0, '0, 0, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);

        // reset asserted mid-FILL: outputs clear asynchronously, no pulse follows
        @(negedge clk);
        dc_miss = 1'b1; dc_addr = 32'h0000_2000; dc_dirty = 1'b0;
        @(negedge clk);
        dc_miss = 1'b0;
        chk("abort_rd", LW'(mem_rd), LW'(1));
        #2 rsn = 1'b0;
        #1 check_zero();
        @(negedge clk); @(negedge clk); rsn = 1'b1;
        m_miss = '0; m_wb = '0; last_addr = '0; last_data = '0;
        repeat (3) begin @(negedge clk); chk("abort_idle", LW'(busy), '0); end

        // dirty victim with a two-cycle writeback wait
        do_miss(32'h0000_4000, 1'b1, 32'h0000_8008, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                2, 0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A, 1'b0);
        // read held for six cycles before ack
        do_miss(32'h0000_567F, 1'b0, '0, '0, 0, 5, 128'h0BAD_F00D_0000_0001_0000_0002_0000_0003, 1'b0);
        // new misses presented during WB/FILL/RESP are ignored
        do_miss(32'h0000_6004, 1'b1, 32'h0000_7000, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                1, 1, 128'hFEED_FACE_0000_0000_0000_0000_C0DE_C0DE, 1'b1);

        // miss left asserted through RESP not taken; spurious acks in IDLE ignored
        @(negedge clk);
        chk("resp_miss_busy", LW'(busy), '0);
        chk("resp_miss_cnt", LW'(miss_cnt), LW'(m_miss));
        dc_miss = 1'b0; mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_busy", LW'(busy), '0);
            chk("spur_rd", LW'(mem_rd), '0);
            chk("spur_wr", LW'(mem_wr), '0);
        end
        mem_ack = 1'b0;

        // back-to-back: second miss raised in RESP, accepted one cycle later
        do_miss(32'h0000_9000, 1'b0, '0, '0, 0, 0, 128'h9, 1'b0);
        dc_miss = 1'b1; dc_addr = 32'h0000_A01C; dc_dirty = 1'b0;
        do_miss(32'h0000_A01C, 1'b0, '0, '0, 0, 0, 128'hA, 1'b0);

        // counter wrap with a 4-bit counter
        @(negedge clk); rsn = 1'b0;
        @(negedge clk); rsn = 1'b1;
        m_miss = '0; m_wb = '0; last_addr = '0; last_data = '0;
        for (int i = 0; i < 17; i++)
            do_miss(32'h0001_0000 + 32'(i * 16), 1'b0, '0, '0, 0, 0, 128'(i + 100), 1'b0);
        @(negedge clk);
        chk("wrap_miss_cnt", LW'(miss_cnt), LW'(1));
        chk("wrap_wb_cnt", LW'(wb_cnt), '0);
        repeat (2) @(negedge clk);
        chk("sb_drained", LW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
